envase_lotes_param: RTL and testbench
=====================================

Name: envase_lotes_param

Overview:
- Parametrised successor to the fixed capping, dispenser and dozen-counter logic of the bottling line.
- Manages the cork magazine: consumption per capping request, automatic refill from warehouse stock, and the empty alarm.
- Groups approved bottles into batches of BATCH_SIZE and counts discards.
- Sits between the main line FSM and the display decoders, clocked by the 1 s system clock.

Parameters:
CORK_MAX, 15, magazine capacity (corks)
REFILL_LEVEL, 5, refill starts when cork_count <= this value
LOAD_QTY, 20, corks added to warehouse stock per stock_load pulse
STOCK_W, 7, width of stock_count (saturates at 2^STOCK_W-1)
DISP_CYCLES, 2, clock cycles per single-cork transfer, >=1
BATCH_SIZE, 12, approved bottles per batch, >=2
MAX_BATCHES, 10, batch_count wraps to 0 after MAX_BATCHES-1
Derived: CW=clog2(CORK_MAX+1), UW=clog2(BATCH_SIZE), BW=clog2(MAX_BATCHES), RW=8

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cap_req  in  1  level; bottle is at the capping station and requests a cork
qc_pass  in  1  one-cycle pulse; bottle approved
qc_reject  in  1  one-cycle pulse; bottle discarded
stock_load  in  1  one-cycle pulse; operator adds LOAD_QTY corks to stock
cap_grant  out  1  one-cycle pulse; cork consumed, capping actuator fires
cap_alarm  out  1  level; request pending with an empty magazine
disp_busy  out  1  dispenser is transferring
cork_count  out  CW  corks in magazine
stock_count  out  STOCK_W  corks in warehouse
unit_count  out  UW  approved bottles in the current batch
batch_count  out  BW  completed batches, modulo MAX_BATCHES
batch_done  out  1  one-cycle pulse on batch completion
reject_count  out  RW  discarded bottles, saturating at 255

Behaviour:
Reset:
- All counters 0; all outputs 0.
- Both FSMs return to IDLE.
- Reset asserted mid-transfer or mid-grant aborts the operation with no partial count update.

Capping FSM (IDLE, GRANT, HOLD, ALARM):
- IDLE, cap_req=1, cork_count>0 -> GRANT.
- IDLE, cap_req=1, cork_count=0 -> ALARM.
- GRANT: cap_grant=1 for exactly one cycle; cork_count decrements on that edge; next state HOLD.
- HOLD: waits for cap_req=0 -> IDLE. Exactly one grant per request.
- ALARM: cap_alarm=1.
  - cork_count>0 and cap_req=1 -> GRANT.
  - cap_req=0 -> IDLE.
- Grant latency from cap_req rise with corks available: cap_grant high in the cycle after the edge that samples cap_req.

Dispenser FSM (IDLE, MOVE):
- IDLE -> MOVE when cork_count<=REFILL_LEVEL and stock_count>0.
- MOVE: disp_busy=1. Every DISP_CYCLES cycles one cork moves: stock_count-1, cork_count+1.
- MOVE -> IDLE when cork_count reaches CORK_MAX or stock_count reaches 0 (evaluated after each transfer).
- Same-edge consume and transfer: cork_count net unchanged, stock_count-1.
- cork_count never exceeds CORK_MAX and never underflows.

Stock:
- stock_load adds LOAD_QTY, saturating at 2^STOCK_W-1.
- stock_load on the same edge as a transfer: net +LOAD_QTY-1, still saturating.

Batch counter:
- qc_pass increments unit_count.
- When unit_count=BATCH_SIZE-1 and qc_pass=1:
  - unit_count->0;
  - batch_count+1, wrapping MAX_BATCHES-1 -> 0;
  - batch_done=1 in the following cycle.
- qc_reject increments reject_count (saturating at 255).
- qc_pass and qc_reject asserted together: reject wins, unit_count unchanged.

Test Plan:
- Reset, stock_load x1 -> stock 20; dispenser runs until cork_count=15, stock_count=5, disp_busy falls; one transfer per 2 cycles, 15 transfers over 30 cycles.
- cork_count=15, 10 cap_req pulses (each 3 cycles high) -> 10 cap_grant pulses, cork_count 5; refill starts; with stock 5, ends at cork_count=10, stock_count=0.
- cork_count=0, stock=0, cap_req held -> cap_alarm=1, no grant; stock_load -> refill -> first cork arrives -> cap_grant pulse, cap_alarm=0.
- 12 qc_pass pulses -> unit_count 0..11 then 0, batch_count=1, one batch_done pulse; 120 passes -> batch_count wraps to 0.
- qc_pass+qc_reject same cycle -> reject_count+1, unit_count unchanged; 300 rejects -> reject_count=255.
- Reset asserted during MOVE with cork_count=8 -> all counters 0 immediately (asynchronous), disp_busy=0.

Source files
------------

// File: rtl/envase_lotes_param_if.sv
`default_nettype none
// ============================================================================
// Module   : envase_lotes_param_if
// Brief    : Line-side bus of the cork magazine / batch counter block.
// Revision : 1.0 - initial release
// ============================================================================
interface envase_lotes_param_if #(
  parameter int CORK_MAX    = 15,
  parameter int STOCK_W     = 7,
  parameter int BATCH_SIZE  = 12,
  parameter int MAX_BATCHES = 10
);
  localparam int CW = $clog2(CORK_MAX + 1);
  localparam int UW = $clog2(BATCH_SIZE);
  localparam int BW = (MAX_BATCHES > 1) ? $clog2(MAX_BATCHES) : 1;
  localparam int RW = 8;

  logic               cap_req;
  logic               qc_pass;
  logic               qc_reject;
  logic               stock_load;
  logic               cap_grant;
  logic               cap_alarm;
  logic               disp_busy;
  logic [CW-1:0]      cork_count;
  logic [STOCK_W-1:0] stock_count;
  logic [UW-1:0]      unit_count;
  logic [BW-1:0]      batch_count;
  logic               batch_done;
  logic [RW-1:0]      reject_count;

  modport master (
    output cap_req, qc_pass, qc_reject, stock_load,
    input  cap_grant, cap_alarm, disp_busy, cork_count, stock_count,
           unit_count, batch_count, batch_done, reject_count
  );

  modport slave (
    input  cap_req, qc_pass, qc_reject, stock_load,
    output cap_grant, cap_alarm, disp_busy, cork_count, stock_count,
           unit_count, batch_count, batch_done, reject_count
  );
endinterface
`default_nettype wire

// File: rtl/envase_lotes_param.sv
`default_nettype none
// ============================================================================
// Module   : envase_lotes_param
// Brief    : Cork magazine (capping + refill dispenser) and batch/reject counters.
// Revision : 1.0 - initial release
// ============================================================================
module envase_lotes_param #(
  parameter int CORK_MAX     = 15,
  parameter int REFILL_LEVEL = 5,
  parameter int LOAD_QTY     = 20,
  parameter int STOCK_W      = 7,
  parameter int DISP_CYCLES  = 2,
  parameter int BATCH_SIZE   = 12,
  parameter int MAX_BATCHES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  envase_lotes_param_if.slave  bus
);
  localparam int CW = $clog2(CORK_MAX + 1);
  localparam int UW = $clog2(BATCH_SIZE);
  localparam int BW = (MAX_BATCHES > 1) ? $clog2(MAX_BATCHES) : 1;
  localparam int RW = 8;
  localparam int TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  localparam logic [CW-1:0]      c_cork_max   = CW'(CORK_MAX);
  localparam logic [STOCK_W-1:0] c_stock_max  = {STOCK_W{1'b1}};
  localparam logic [UW-1:0]      c_unit_last  = UW'(BATCH_SIZE - 1);
  localparam logic [BW-1:0]      c_batch_last = BW'(MAX_BATCHES - 1);
  localparam logic [TW-1:0]      c_tick_last  = TW'(DISP_CYCLES - 1);
  localparam logic [RW-1:0]      c_reject_max = {RW{1'b1}};

  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_GRANT = 2'd1,
    CAP_HOLD  = 2'd2,
    CAP_ALARM = 2'd3
  } cap_state_t;

  typedef enum logic [0:0] {
    DISP_IDLE = 1'b0,
    DISP_MOVE = 1'b1
  } disp_state_t;

  cap_state_t         r_cap_state;
  disp_state_t        r_disp_state;
  logic               r_cap_grant;
  logic               r_cap_alarm;
  logic [TW-1:0]      r_tick;
  logic [CW-1:0]      r_cork;
  logic [STOCK_W-1:0] r_stock;
  logic [UW-1:0]      r_unit;
  logic [BW-1:0]      r_batch;
  logic               r_batch_done;
  logic [RW-1:0]      r_reject;

  logic               w_consume;
  logic               w_due;
  logic               w_xfer;
  logic               w_refill_low;
  logic [CW-1:0]      w_cork_next;
  logic [31:0]        w_stock_sum;
  logic [STOCK_W-1:0] w_stock_next;

  // A transfer is skipped only if the magazine is full with no cork leaving on the same edge.
  assign w_consume    = (r_cap_state == CAP_GRANT) && (r_cork != '0);
  assign w_due        = (r_disp_state == DISP_MOVE) && (r_tick == c_tick_last);
  assign w_xfer       = w_due && (r_stock != '0) && ((r_cork != c_cork_max) || w_consume);
  assign w_cork_next  = r_cork + CW'(w_xfer) - CW'(w_consume);
  assign w_stock_sum  = 32'(r_stock) + (bus.stock_load ? 32'(LOAD_QTY) : 32'd0) - 32'(w_xfer);
  assign w_stock_next = (w_stock_sum > 32'(c_stock_max)) ? c_stock_max : w_stock_sum[STOCK_W-1:0];
  assign w_refill_low = (32'(r_cork) <= 32'(REFILL_LEVEL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_state <= CAP_IDLE;
      r_cap_grant <= 1'b0;
      r_cap_alarm <= 1'b0;
    end else begin
      r_cap_grant <= 1'b0;
      r_cap_alarm <= 1'b0;
      case (r_cap_state)
        CAP_IDLE: begin
          if (bus.cap_req) begin
            if (r_cork != '0) begin
              r_cap_state <= CAP_GRANT;
              r_cap_grant <= 1'b1;
            end else begin
              r_cap_state <= CAP_ALARM;
              r_cap_alarm <= 1'b1;
            end
          end
        end
        CAP_GRANT: r_cap_state <= CAP_HOLD;
        CAP_HOLD: begin
          if (!bus.cap_req) r_cap_state <= CAP_IDLE;
        end
        CAP_ALARM: begin
          if (!bus.cap_req) begin
            r_cap_state <= CAP_IDLE;
          end else if (r_cork != '0) begin
            r_cap_state <= CAP_GRANT;
            r_cap_grant <= 1'b1;
          end else begin
            r_cap_alarm <= 1'b1;
          end
        end
        default: r_cap_state <= CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_state <= DISP_IDLE;
      r_tick       <= '0;
    end else begin
      case (r_disp_state)
        DISP_IDLE: begin
          if (w_refill_low && (r_stock != '0)) begin
            r_disp_state <= DISP_MOVE;
            r_tick       <= '0;
          end
        end
        DISP_MOVE: begin
          if (w_due) begin
            r_tick <= '0;
            if (!w_xfer || (w_cork_next == c_cork_max) || (w_stock_next == '0))
              r_disp_state <= DISP_IDLE;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_disp_state <= DISP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cork  <= '0;
      r_stock <= '0;
    end else begin
      r_cork  <= w_cork_next;
      r_stock <= w_stock_next;
    end
  end

  // A simultaneous reject masks the pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_unit       <= '0;
      r_batch      <= '0;
      r_batch_done <= 1'b0;
      r_reject     <= '0;
    end else begin
      r_batch_done <= 1'b0;
      if (bus.qc_reject) begin
        if (r_reject != c_reject_max) r_reject <= r_reject + 1'b1;
      end else if (bus.qc_pass) begin
        if (r_unit == c_unit_last) begin
          r_unit       <= '0;
          r_batch      <= (r_batch == c_batch_last) ? '0 : r_batch + 1'b1;
          r_batch_done <= 1'b1;
        end else begin
          r_unit <= r_unit + 1'b1;
        end
      end
    end
  end

  assign bus.cap_grant    = r_cap_grant;
  assign bus.cap_alarm    = r_cap_alarm;
  assign bus.disp_busy    = (r_disp_state == DISP_MOVE);
  assign bus.cork_count   = r_cork;
  assign bus.stock_count  = r_stock;
  assign bus.unit_count   = r_unit;
  assign bus.batch_count  = r_batch;
  assign bus.batch_done   = r_batch_done;
  assign bus.reject_count = r_reject;
endmodule
`default_nettype wire

// File: tb/tb_envase_lotes_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_envase_lotes_param
// Brief    : Directed bench with a cycle model for envase_lotes_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_envase_lotes_param;
  localparam int CORK_MAX = 15, REFILL_LEVEL = 5, LOAD_QTY = 20, STOCK_W = 7;
  localparam int DISP_CYCLES = 2, BATCH_SIZE = 12, MAX_BATCHES = 10;
  localparam int SMAX = (1 << STOCK_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  envase_lotes_param_if #(.CORK_MAX(CORK_MAX), .STOCK_W(STOCK_W),
                          .BATCH_SIZE(BATCH_SIZE), .MAX_BATCHES(MAX_BATCHES)) bus ();

  envase_lotes_param #(
    .CORK_MAX(CORK_MAX), .REFILL_LEVEL(REFILL_LEVEL), .LOAD_QTY(LOAD_QTY),
    .STOCK_W(STOCK_W), .DISP_CYCLES(DISP_CYCLES), .BATCH_SIZE(BATCH_SIZE),
    .MAX_BATCHES(MAX_BATCHES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: magazine/stock as plain integers, request served flag, refill tick.
  int m_cork = 0, m_stock = 0, m_unit = 0, m_batch = 0, m_reject = 0, m_tick = 0;
  bit m_grant = 0, m_alarm = 0, m_served = 0, m_moving = 0, m_done = 0;
  int x_xfer, x_cons, x_nc, x_ns;
  bit x_due, x_ng, x_na;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cork = 0; m_stock = 0; m_unit = 0; m_batch = 0; m_reject = 0; m_tick = 0;
      m_grant = 0; m_alarm = 0; m_served = 0; m_moving = 0; m_done = 0;
    end else begin
      x_cons = m_grant ? 1 : 0;
      x_due  = m_moving && (m_tick == DISP_CYCLES - 1);
      x_xfer = (x_due && m_stock > 0 && (m_cork < CORK_MAX || x_cons == 1)) ? 1 : 0;
      x_nc   = m_cork - x_cons + x_xfer;
      x_ns   = m_stock - x_xfer + (bus.stock_load ? LOAD_QTY : 0);
      if (x_ns > SMAX) x_ns = SMAX;
      x_ng = 0; x_na = 0;
      if (m_grant) m_served = 1;
      else if (m_served) begin
        if (!bus.cap_req) m_served = 0;
      end else if (bus.cap_req) begin
        if (m_cork > 0) x_ng = 1; else x_na = 1;
      end
      if (!m_moving) begin
        if (m_cork <= REFILL_LEVEL && m_stock > 0) begin m_moving = 1; m_tick = 0; end
      end else if (x_due) begin
        m_tick = 0;
        if (x_xfer == 0 || x_nc == CORK_MAX || x_ns == 0) m_moving = 0;
      end else m_tick++;
      m_done = 0;
      if (bus.qc_reject) begin
        if (m_reject < 255) m_reject++;
      end else if (bus.qc_pass) begin
        if (m_unit == BATCH_SIZE - 1) begin
          m_unit = 0; m_batch = (m_batch + 1) % MAX_BATCHES; m_done = 1;
        end else m_unit++;
      end
      m_cork = x_nc; m_stock = x_ns; m_grant = x_ng; m_alarm = x_na;
    end
  end

  int grant_cnt = 0, done_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("cap_grant",    32'(bus.cap_grant),    32'(m_grant));
      chk("cap_alarm",    32'(bus.cap_alarm),    32'(m_alarm));
      chk("disp_busy",    32'(bus.disp_busy),    32'(m_moving));
      chk("cork_count",   32'(bus.cork_count),   32'(m_cork));
      chk("stock_count",  32'(bus.stock_count),  32'(m_stock));
      chk("unit_count",   32'(bus.unit_count),   32'(m_unit));
      chk("batch_count",  32'(bus.batch_count),  32'(m_batch));
      chk("batch_done",   32'(bus.batch_done),   32'(m_done));
      chk("reject_count", 32'(bus.reject_count), 32'(m_reject));
      if (bus.cap_grant)  grant_cnt++;
      if (bus.batch_done) done_cnt++;
      if (bus.disp_busy)  busy_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_pulse();
    @(negedge clk) bus.cap_req = 1'b1;
    step(3);
    bus.cap_req = 1'b0;
    step(2);
  endtask

  task automatic pass_pulse();
    @(negedge clk) bus.qc_pass = 1'b1;
    @(negedge clk) bus.qc_pass = 1'b0;
  endtask

  task automatic load_pulse();
    @(negedge clk) bus.stock_load = 1'b1;
    @(negedge clk) bus.stock_load = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cork"},   32'(bus.cork_count),   0);
    chk({tag, "_stock"},  32'(bus.stock_count),  0);
    chk({tag, "_unit"},   32'(bus.unit_count),   0);
    chk({tag, "_batch"},  32'(bus.batch_count),  0);
    chk({tag, "_reject"}, 32'(bus.reject_count), 0);
    chk({tag, "_busy"},   32'(bus.disp_busy),    0);
    chk({tag, "_grant"},  32'(bus.cap_grant),    0);
    chk({tag, "_alarm"},  32'(bus.cap_alarm),    0);
    chk({tag, "_done"},   32'(bus.batch_done),   0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, b0, d0, got;
    bus.cap_req = 0; bus.qc_pass = 0; bus.qc_reject = 0; bus.stock_load = 0;
    reset = 1'b1;
    step(3);
    chk_all_zero("reset");
    reset = 1'b0;
    step(2);

    // Initial fill: 20 loaded, 15 moved at one per 2 cycles.
    b0 = busy_cnt;
    load_pulse();
    step(40);
    chk("fill_cork",  32'(bus.cork_count),  15);
    chk("fill_stock", 32'(bus.stock_count), 5);
    chk("fill_busy",  32'(bus.disp_busy),   0);
    chk("fill_busy_cycles", 32'(busy_cnt - b0), 30);

    // Ten requests drain to the refill level, refill exhausts the stock.
    g0 = grant_cnt;
    repeat (10) req_pulse();
    chk("drain_grants", 32'(grant_cnt - g0), 10);
    step(20);
    chk("refill_cork",  32'(bus.cork_count),  10);
    chk("refill_stock", 32'(bus.stock_count), 0);

    // Empty magazine: alarm until a refilled cork arrives.
    repeat (10) req_pulse();
    chk("empty_cork", 32'(bus.cork_count), 0);
    g0 = grant_cnt;
    @(negedge clk) bus.cap_req = 1'b1;
    step(3);
    chk("alarm_on", 32'(bus.cap_alarm), 1);
    chk("alarm_no_grant", 32'(grant_cnt - g0), 0);
    load_pulse();
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (bus.cap_grant) got = 1;
    end
    chk("alarm_grant_seen", 32'(got), 1);
    chk("alarm_cleared", 32'(bus.cap_alarm), 0);
    bus.cap_req = 1'b0;
    step(40);

    // Batching: 12 passes make one batch, 120 wrap the batch counter.
    d0 = done_cnt;
    repeat (12) pass_pulse();
    step(2);
    chk("batch1_unit",  32'(bus.unit_count),  0);
    chk("batch1_count", 32'(bus.batch_count), 1);
    chk("batch1_done",  32'(done_cnt - d0),   1);
    repeat (108) pass_pulse();
    step(2);
    chk("wrap_count", 32'(bus.batch_count), 0);
    chk("wrap_done",  32'(done_cnt - d0),   10);

    // Reject priority and saturation.
    repeat (3) pass_pulse();
    @(negedge clk) begin bus.qc_pass = 1'b1; bus.qc_reject = 1'b1; end
    @(negedge clk) begin bus.qc_pass = 1'b0; bus.qc_reject = 1'b0; end
    chk("both_reject", 32'(bus.reject_count), 1);
    chk("both_unit",   32'(bus.unit_count),   3);
    @(negedge clk) bus.qc_reject = 1'b1;
    step(299);
    bus.qc_reject = 1'b0;
    step(2);
    chk("reject_sat", 32'(bus.reject_count), 255);

    // Asynchronous reset in the middle of a refill.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    load_pulse();
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (bus.cork_count == 4'd8) got = 1;
    end
    chk("reach_cork8", 32'(got), 1);
    chk("cork8_busy", 32'(bus.disp_busy), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk) reset = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
